// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDiscard,
    StHold
  } if_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; otherwise a bubble is inserted.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    valid_d = 1'b0;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      instr_q <= NopInstr;
      pc_q    <= 32'h0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding imem request, stall hold buffer, flush discard.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        mem_stall_o,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  if_state_e   state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic        load_en;
  logic [31:0] load_instr;
  logic [31:0] load_pc;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    load_en     = 1'b0;
    load_instr  = imem_rdata_i;
    load_pc     = addr_q;
    mem_stall_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        mem_stall_o = start_i;
        if (start_i && !flush_i) begin
          state_d = StWait;
          req_d   = 1'b1;
          addr_d  = pc_i;
        end
      end
      StWait: begin
        mem_stall_o = !imem_ack_i;
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = StIdle;
          if (!flush_i) begin
            if (stall_i) begin
              state_d     = StHold;
              buf_instr_d = imem_rdata_i;
              buf_pc_d    = addr_q;
            end else begin
              load_en = 1'b1;
            end
          end
        end else if (flush_i) begin
          state_d = StDiscard;
        end
      end
      // The request cannot be withdrawn, so wait out its ack and drop the data.
      StDiscard: begin
        mem_stall_o = 1'b1;
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StHold: begin
        mem_stall_o = 1'b1;
        load_instr  = buf_instr_q;
        load_pc     = buf_pc_q;
        if (flush_i) begin
          state_d = StIdle;
        end else if (!stall_i) begin
          load_en = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      addr_q      <= 32'h0;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;

  if_id_reg u_if_id_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .stall_i (stall_i),
    .load_i  (load_en),
    .instr_i (load_instr),
    .pc_i    (load_pc),
    .valid_o (valid_o),
    .instr_o (instr_o),
    .pc_o    (pc_o)
  );

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have ports, one per line, clock and reset first (name  direction  width  meaning):
  clk_i  in  1  single clock; all state updates on rising edge
  rst_i  in  1  synchronous, active-low reset; sampled on rising edge of clk_i
  start_i  in  1  fetch enable; 0 = no new requests issued
  pc_i  in  32  fetch address from PC register
  stall_i  in  1  hazard stall from decode; 1 = hold IF/ID
  flush_i  in  1  branch/jump redirect; 1 = kill in-flight and buffered fetch
  imem_req_o  out  1  instruction-memory request, registered
  imem_addr_o  out  32  request address, stable while imem_req_o=1
  imem_ack_i  in  1  memory response valid, one-cycle pulse
  imem_rdata_i  in  32  instruction word, valid when imem_ack_i=1
  mem_stall_o  out  1  combinational; 1 = PC must not advance
  valid_o  out  1  IF/ID entry valid
  instr_o  out  32  IF/ID instruction
  pc_o  out  32  IF/ID instruction address
REQ-002 SHALL have no parameters; all widths fixed at 32.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, DISCARD, HOLD.
REQ-004 IDLE: start_i=1 and flush_i=0 -> latch pc_i into imem_addr_o, set imem_req_o=1, go WAIT; else stay IDLE with imem_req_o=0.
REQ-005 WAIT: imem_req_o=1, imem_addr_o held; ack=0 and flush_i=0 -> stay; ack=0 and flush_i=1 -> DISCARD.
REQ-006 WAIT with ack=1: flush_i=1 -> drop data, IDLE; else stall_i=1 -> capture {rdata, addr} in hold buffer, HOLD; else load IF/ID {instr_o=rdata, pc_o=addr, valid_o=1}, IDLE.
REQ-007 DISCARD: imem_req_o=1 until ack (requests are never withdrawn); on ack discard data, go IDLE.
REQ-008 HOLD: imem_req_o=0; flush_i=1 -> drop buffer, IDLE; else stall_i=0 -> load buffer into IF/ID with valid_o=1, IDLE; else stay.
REQ-009 IF/ID each edge, priority: flush_i=1 -> valid_o=0; else stall_i=1 -> hold all three outputs; else new instruction per REQ-006/008 -> load; else valid_o=0 (bubble), instr_o/pc_o unchanged.
REQ-010 mem_stall_o=1 when (WAIT and ack=0) or DISCARD or HOLD or (IDLE and start_i=1); 0 otherwise, including WAIT cycle with ack=1.
REQ-011 Latency: request in cycle after IDLE; zero-wait memory (ack in first WAIT cycle) -> IF/ID valid 2 cycles after IDLE; throughput one instruction per 2 cycles.
REQ-012 imem_ack_i outside WAIT/DISCARD SHALL be ignored.
REQ-013 start_i=0 mid-WAIT SHALL NOT cancel the outstanding request.
REQ-014 pc_i change during WAIT SHALL NOT affect imem_addr_o.

Reset
REQ-015 rst_i=0 at edge: state IDLE, imem_req_o=0, imem_addr_o=0, valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=0, hold buffer cleared.
REQ-016 Reset mid-WAIT SHALL abandon the request; a late ack after reset is ignored per REQ-012.

Structure
REQ-017 Shared package holds FSM state enum and NOP constant 32'h0000_0013.
REQ-018 IF/ID register (valid/instr/pc with flush > stall > load > bubble priority) SHALL be sub-module if_id_reg.

Verification
REQ-019 Zero-wait: start_i=1, pc_i=0x100, ack in first WAIT cycle, rdata=0x00A00093 -> 2 cycles later valid_o=1, instr_o=0x00A00093, pc_o=0x100.
REQ-020 3-cycle memory latency at pc_i=0x104 -> mem_stall_o=1 for 3 WAIT cycles, imem_addr_o=0x104 stable, then IF/ID loads.
REQ-021 stall_i=1 when ack arrives for 0x108 -> HOLD, IF/ID unchanged; stall_i drops -> next edge pc_o=0x108, valid_o=1.
REQ-022 flush_i=1 during WAIT (no ack) -> DISCARD, imem_req_o stays 1, ack data dropped, valid_o=0, then IDLE.
REQ-023 flush_i=1 and stall_i=1 same cycle in HOLD -> buffer dropped, valid_o=0 (flush wins).
REQ-024 rst_i=0 during WAIT, ack next cycle -> all outputs at REQ-015 values, no IF/ID load.
